lcd_ctrl: RTL and testbench

HD44780-style character LCD sequencer sitting between the CPU's memory-mapped LCD register and the board's 16x2 LCD pins. After reset it runs the power-up wait and a fixed init command sequence. It then accepts command/data bytes over a valid/ready handshake. It generates the RS/RW/DATA setup, the EN pulse and the post-write wait for each byte, so software never bit-bangs EN timing. Its packed output word uses the same layout as the LCD I/O register: bit31 ON, [10:8] {EN,RS,RW}, [7:0] DATA.

---
 rtl/lcd_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_lcd_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ctrl.sv
// HD44780-style 16x2 LCD sequencer: power-up wait, fixed init bytes, then byte writes with EN timing.
// Latency: accept edge to next ready = T_SETUP + T_EN + T_HOLD + (T_CLR for clear/home commands, else T_CMD).
// Backpressure: req_ready_o is high only in IDLE after init; requests presented earlier are held by the source.
module lcd_ctrl #(
  parameter int unsigned T_PWR   = 750000,
  parameter int unsigned T_SETUP = 4,
  parameter int unsigned T_EN    = 25,
  parameter int unsigned T_HOLD  = 4,
  parameter int unsigned T_CMD   = 2000,
  parameter int unsigned T_CLR   = 82000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  output logic        init_done_o,
  output logic        busy_o,
  output logic [7:0]  lcd_data_o,
  output logic        lcd_rs_o,
  output logic        lcd_rw_o,
  output logic        lcd_en_o,
  output logic        lcd_on_o,
  output logic [31:0] lcd_o
);

  // Largest timing parameter sets the phase counter width; one spare bit keeps T-1 in range.
  localparam int unsigned M_A   = (T_PWR > T_SETUP) ? T_PWR : T_SETUP;
  localparam int unsigned M_B   = (M_A > T_EN) ? M_A : T_EN;
  localparam int unsigned M_C   = (M_B > T_HOLD) ? M_B : T_HOLD;
  localparam int unsigned M_D   = (M_C > T_CMD) ? M_C : T_CMD;
  localparam int unsigned T_MAX = (M_D > T_CLR) ? M_D : T_CLR;
  localparam int unsigned CW    = $clog2(T_MAX) + 1;

  // Last count value of each fixed-length phase.
  localparam logic [CW-1:0] PWR_LAST   = CW'(T_PWR - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(T_EN - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(T_CLR - 1);

  typedef enum logic [2:0] {
    S_PWR,
    S_LOAD,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_IDLE
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic [1:0]    idx_q;
  logic          rs_q;
  logic [7:0]    data_q;
  logic          en_q;
  logic          on_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;

  logic          accept;
  logic          idx_inc;
  logic          done_set;
  logic          clr_sel;
  logic [CW-1:0] wait_last;
  logic [7:0]    init_byte;

  // Init command ROM: function set 8-bit/2-line, display on, clear, entry mode increment.
  always_comb begin
    init_byte = 8'h38;
    case (idx_q)
      2'd0:    init_byte = 8'h38;
      2'd1:    init_byte = 8'h0C;
      2'd2:    init_byte = 8'h01;
      default: init_byte = 8'h06;
    endcase
  end

  // Clear (0x01) and return-home (0x02/0x03) commands need the long post-write wait.
  always_comb begin
    clr_sel   = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));
    wait_last = clr_sel ? CLR_LAST : CMD_LAST;
  end

  // Next-state decode; each timed phase ends when the counter reaches its last value.
  always_comb begin
    state_d  = state_q;
    accept   = 1'b0;
    idx_inc  = 1'b0;
    done_set = 1'b0;
    case (state_q)
      S_PWR: begin
        if (cnt_q == PWR_LAST) state_d = S_LOAD;
      end
      S_LOAD: begin
        state_d = S_SETUP;
      end
      S_SETUP: begin
        if (cnt_q == SETUP_LAST) state_d = S_PULSE;
      end
      S_PULSE: begin
        if (cnt_q == EN_LAST) state_d = S_HOLD;
      end
      S_HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (cnt_q == wait_last) begin
          if (done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == 2'd3) begin
            done_set = 1'b1;
            state_d  = S_IDLE;
          end else begin
            idx_inc = 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          accept  = 1'b1;
          state_d = S_SETUP;
        end
      end
      default: begin
        state_d = S_PWR;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= S_PWR;
    else       state_q <= state_d;
  end

  // Phase counter: restarts from zero on every phase entry, parked in IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q != S_IDLE) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // Init byte index advances at the end of each init write's wait.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)        idx_q <= 2'd0;
    else if (idx_inc) idx_q <= idx_q + 2'd1;
  end

  // RS/DATA latch: loaded from the init ROM or an accepted request, held otherwise.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rs_q   <= 1'b0;
      data_q <= 8'h00;
    end else if (state_q == S_LOAD) begin
      rs_q   <= 1'b0;
      data_q <= init_byte;
    end else if (accept) begin
      rs_q   <= req_rs_i;
      data_q <= req_data_i;
    end
  end

  // Pin and status registers follow the next state so they line up with the state itself.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      en_q    <= 1'b0;
      on_q    <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      en_q    <= (state_d == S_PULSE);
      on_q    <= 1'b1;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= done_q | done_set;
    end
  end

  assign req_ready_o = ready_q;
  assign init_done_o = done_q;
  assign busy_o      = busy_q;
  assign lcd_data_o  = data_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = en_q;
  assign lcd_on_o    = on_q;
  assign lcd_o       = {on_q, 20'b0, en_q, rs_q, 1'b0, data_q};

endmodule

// File: tb/tb_lcd_ctrl.sv
// Bench for lcd_ctrl: per-cycle reference schedule, request table, multi-cycle corner sequences.
// Latency: checks every cycle on the falling edge against a timeline computed from the timing rules.
// Backpressure: the source holds each request until it observes ready, as a real CPU port would.
module tb_lcd_ctrl;

  localparam int TP = 10;
  localparam int TS = 2;
  localparam int TE = 4;
  localparam int TH = 2;
  localparam int TC = 8;
  localparam int TL = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_rs = 1'b0;
  logic [7:0]  req_data = 8'h00;
  logic        req_ready_o;
  logic        init_done_o;
  logic        busy_o;
  logic [7:0]  lcd_data_o;
  logic        lcd_rs_o;
  logic        lcd_rw_o;
  logic        lcd_en_o;
  logic        lcd_on_o;
  logic [31:0] lcd_o;

  lcd_ctrl #(
    .T_PWR(TP), .T_SETUP(TS), .T_EN(TE), .T_HOLD(TH), .T_CMD(TC), .T_CLR(TL)
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready_o),
    .req_rs_i(req_rs),
    .req_data_i(req_data),
    .init_done_o(init_done_o),
    .busy_o(busy_o),
    .lcd_data_o(lcd_data_o),
    .lcd_rs_o(lcd_rs_o),
    .lcd_rw_o(lcd_rw_o),
    .lcd_en_o(lcd_en_o),
    .lcd_on_o(lcd_on_o),
    .lcd_o(lcd_o)
  );

  always #5 clk = ~clk;

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
    vec_cnt++;
    if (act !== want) begin
      err_cnt++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, want);
    end
  endtask

  task automatic fail_now(input string name);
    vec_cnt++;
    err_cnt++;
    $display("FAIL %s at t=%0t: bound expired", name, $time);
  endtask

  // ---------------- reference schedule ----------------
  // n = rising edges since reset release, sampled on the falling edge.
  logic [7:0] init_bytes [4] = '{8'h38, 8'h0C, 8'h01, 8'h06};
  int         n = 0;
  bit         m_idle, m_done;
  int         m_start, m_len, m_idx;
  logic       m_rs, m_lrs;
  logic [7:0] m_dat, m_ldat;

  typedef struct { int n; logic rs; logic [7:0] dat; } pulse_t;
  pulse_t pulse_q[$];

  function automatic int write_len(input logic rs, input logic [7:0] d);
    int w;
    w = (!rs && d >= 8'h01 && d <= 8'h03) ? TL : TC;
    return TS + TE + TH + w;
  endfunction

  task automatic model_reset();
    m_idle  = 0;
    m_done  = 0;
    m_idx   = 0;
    m_start = TP + 1;          // PWR occupies samples 0..TP-1, LOAD is sample TP
    m_rs    = 1'b0;
    m_dat   = init_bytes[0];
    m_len   = write_len(1'b0, init_bytes[0]);
    m_lrs   = 1'b0;
    m_ldat  = 8'h00;
  endtask

  initial begin : monitor
    logic       e_en, e_rs, e_rdy, prev_en;
    logic [7:0] e_dat;
    logic [31:0] e_o;
    int off;
    prev_en = 1'b0;
    model_reset();
    forever begin
      @(negedge clk);
      if (rst) begin
        n = 0;
        model_reset();
        prev_en = 1'b0;
        pulse_q.delete();
        check("reset_state", {lcd_o, req_ready_o, busy_o, init_done_o, lcd_en_o}, {32'h0, 1'b0, 1'b1, 1'b0, 1'b0});
      end else begin
        n = n + 1;
        if (m_idle) begin
          e_en = 1'b0; e_rs = m_lrs; e_dat = m_ldat; e_rdy = 1'b1;
        end else if (n < m_start) begin
          e_en = 1'b0; e_rs = m_lrs; e_dat = m_ldat; e_rdy = 1'b0;
        end else begin
          off   = n - m_start;
          e_en  = (off >= TS) && (off < TS + TE);
          e_rs  = m_rs; e_dat = m_dat; e_rdy = 1'b0;
        end
        e_o = {1'b1, 20'b0, e_en, e_rs, 1'b0, e_dat};
        check("cycle",
              {lcd_o, lcd_on_o, lcd_en_o, lcd_rs_o, lcd_rw_o, lcd_data_o, req_ready_o, busy_o, init_done_o},
              {e_o, 1'b1, e_en, e_rs, 1'b0, e_dat, e_rdy, !e_rdy, m_done});
        if (lcd_en_o && !prev_en) pulse_q.push_back('{n, lcd_rs_o, lcd_data_o});
        prev_en = lcd_en_o;
        // advance the schedule for the next sample
        if (!m_idle && n >= m_start && (n - m_start) == m_len - 1) begin
          m_lrs  = m_rs;
          m_ldat = m_dat;
          if (!m_done && m_idx < 3) begin
            m_idx   = m_idx + 1;
            m_start = n + 2;   // one LOAD sample precedes the next init byte
            m_rs    = 1'b0;
            m_dat   = init_bytes[m_idx];
            m_len   = write_len(1'b0, m_dat);
          end else begin
            m_done = 1;
            m_idle = 1;
          end
        end else if (m_idle && req_valid) begin
          m_idle  = 0;
          m_start = n + 1;
          m_rs    = req_rs;
          m_dat   = req_data;
          m_len   = write_len(req_rs, req_data);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic rs, input logic [7:0] d, output int acc);
    bit got;
    got = 0;
    acc = -1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_rs = rs; req_data = d;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk); #1;
      if (req_ready_o) begin got = 1; break; end
    end
    if (!got) fail_now("send_ready_timeout");
    @(posedge clk); #1;
    acc = n + 1;
    req_valid = 1'b0;
  endtask

  task automatic wait_ready(output int r);
    r = -1;
    for (int t = 0; t < 400; t++) begin
      @(negedge clk); #1;
      if (req_ready_o) begin r = n; return; end
    end
    fail_now("wait_ready_timeout");
  endtask

  task automatic release_reset();
    repeat (3) @(negedge clk);
    #1 rst = 1'b0;
  endtask

  int exp_pn [4] = '{13, 30, 47, 76};

  task automatic check_init(input string tag);
    int d;
    d = -1;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk); #1;
      if (init_done_o) begin d = n; break; end
    end
    if (d < 0) begin
      fail_now({tag, "_done_timeout"});
      return;
    end
    check({tag, "_done_cycle"}, d, 90);
    check({tag, "_ready_at_done"}, req_ready_o, 1'b1);
    check({tag, "_pulse_count"}, pulse_q.size(), 4);
    if (pulse_q.size() >= 4)
      for (int i = 0; i < 4; i++) begin
        check({tag, "_pulse_cycle"}, pulse_q[i].n, exp_pn[i]);
        check({tag, "_pulse_byte"}, {pulse_q[i].rs, pulse_q[i].dat}, {1'b0, init_bytes[i]});
      end
  endtask

  typedef struct {
    logic        rs;
    logic [7:0]  dat;
    logic [10:0] exp_setup;
    logic [10:0] exp_pulse;
    int          exp_gap;
  } vec_t;

  vec_t tbl [8];

  task automatic run_vec(input vec_t v);
    int acc, r;
    send(v.rs, v.dat, acc);
    @(negedge clk); #1;
    check("vec_setup", lcd_o[10:0], v.exp_setup);
    repeat (TS) @(negedge clk);
    #1;
    check("vec_pulse", lcd_o[10:0], v.exp_pulse);
    wait_ready(r);
    check("vec_ready_gap", r - acc, v.exp_gap);
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: run did not complete, %0d vectors, %0d miscompares", vec_cnt, err_cnt);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int a1, a2, r;
    logic rs_r;
    logic [7:0] d_r;
    tbl[0] = '{1'b1, 8'h41, 11'h241, 11'h641, 16};
    tbl[1] = '{1'b0, 8'h01, 11'h001, 11'h401, 28};
    tbl[2] = '{1'b0, 8'h02, 11'h002, 11'h402, 28};
    tbl[3] = '{1'b0, 8'h03, 11'h003, 11'h403, 28};
    tbl[4] = '{1'b0, 8'h00, 11'h000, 11'h400, 16};
    tbl[5] = '{1'b0, 8'h04, 11'h004, 11'h404, 16};
    tbl[6] = '{1'b1, 8'h01, 11'h201, 11'h601, 16};
    tbl[7] = '{1'b0, 8'h80, 11'h080, 11'h480, 16};

    // power-up and init sequence
    release_reset();
    check_init("init1");

    // table of single writes
    for (int i = 0; i < 8; i++) run_vec(tbl[i]);

    // clear command followed immediately by a pending data byte
    send(1'b0, 8'h01, a1);
    send(1'b1, 8'h42, a2);
    check("b2b_accept_spacing", a2 - a1, 29);
    wait_ready(r);
    check("b2b_second_gap", r - a2, 16);

    // randomized traffic, checked cycle by cycle by the schedule
    for (int i = 0; i < 30; i++) begin
      repeat ($urandom_range(0, 3)) @(posedge clk);
      rs_r = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) d_r = 8'($urandom_range(1, 3));
      else                           d_r = 8'($urandom);
      send(rs_r, d_r, a1);
    end
    wait_ready(r);

    // request held valid across reset release
    @(negedge clk); #1 rst = 1'b1;
    req_valid = 1'b1; req_rs = 1'b1; req_data = 8'h55;
    release_reset();
    check_init("init_pending");
    @(posedge clk); #1 req_valid = 1'b0;
    repeat (40) @(negedge clk);
    #1;
    check("pending_pulse_count", pulse_q.size(), 5);
    if (pulse_q.size() >= 5) begin
      check("pending_pulse_cycle", pulse_q[4].n, 93);
      check("pending_pulse_byte", {pulse_q[4].rs, pulse_q[4].dat}, 9'h155);
    end

    // reset during the second EN-high cycle of a data write
    send(1'b1, 8'h5A, a1);
    repeat (4) @(negedge clk);
    #1;
    check("en_before_reset", lcd_en_o, 1'b1);
    rst = 1'b1;
    #1;
    check("async_en_drop", lcd_en_o, 1'b0);
    check("async_lcd_o_clear", lcd_o, 32'h0);
    release_reset();
    check_init("init_after_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
